// File: rtl/vx_ahb_subordinate_mem_if.sv
// AHB-Lite bus bundle between a manager and vx_ahb_subordinate_mem.
// Handshake: an address phase is taken on a rising edge where HSEL & HTRANS[1] & HREADY; a data phase
// completes on the rising edge where HREADY=1, and HWDATA/HWSTRB must be held stable until then.
interface vx_ahb_subordinate_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    HSEL;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH/8-1:0] HWSTRB;
    logic                    HREADY;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/vx_ahb_subordinate_mem.sv
// AHB-Lite subordinate word memory with wait states, byte strobes and a two-cycle ERROR response.
// Define AHB_SUB_LFSR_WAIT_EN to draw per-transfer wait counts from a 16-bit LFSR instead of WAIT_STATES.
module vx_ahb_subordinate_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_ahb_subordinate_mem_if.slave  ahb,
    output logic [2:0]               dbg_state
);

    localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      mask_q, mask_d;
    logic            write_q, write_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic            is_xfer;
    logic [ADDR_WIDTH:0] rel;
    logic            misalign;
    logic            addr_err;
    logic [3:0]      lane_mask;
    logic [IW-1:0]   idx_new;
    logic [15:0]     w;
    logic            can_accept;
    logic            accept;
    logic            hready;
    logic            hresp;
    logic            rd_en;
    logic            we;
    logic [3:0]      wr_lanes;

    // Address-phase decode; an address below BASE_ADDR wraps rel past SPAN, so one compare covers both bounds.
    always_comb begin
        is_xfer  = ahb.HSEL && ((ahb.HTRANS == 2'b10) || (ahb.HTRANS == 2'b11));
        rel      = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
        misalign = ((ahb.HSIZE == 3'b001) && ahb.HADDR[0]) ||
                   ((ahb.HSIZE == 3'b010) && (ahb.HADDR[1:0] != 2'b00));
        addr_err = (rel >= SPAN) || (ahb.HSIZE > 3'b010) || misalign;
        idx_new  = rel[IW+1:2];
        case (ahb.HSIZE)
            3'b000:  lane_mask = 4'b0001 << ahb.HADDR[1:0];
            3'b001:  lane_mask = 4'b0011 << ahb.HADDR[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

`ifdef AHB_SUB_LFSR_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign w = 16'(32'(lfsr_q) % 32'(WAIT_STATES + 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign w = 16'(WAIT_STATES);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        write_d    = write_q;
        hready     = 1'b1;
        hresp      = 1'b0;
        rd_en      = 1'b0;
        we         = 1'b0;
        can_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                can_accept = 1'b1;
            end
            S_WAIT: begin
                hready = 1'b0;
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                can_accept = 1'b1;
                state_d    = S_IDLE;
                we         = write_q;
                rd_en      = !write_q;
            end
            S_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                hresp      = 1'b1;
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acceptance overrides the default transition so back-to-back beats skip IDLE.
        accept = can_accept && is_xfer;
        if (accept) begin
            idx_d   = idx_new;
            mask_d  = lane_mask;
            write_d = ahb.HWRITE;
            if (addr_err) begin
                cnt_d   = 16'd0;
                state_d = S_ERR1;
            end else begin
                cnt_d   = w;
                state_d = (w != 16'd0) ? S_WAIT : S_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= '0;
            mask_q  <= 4'b0000;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            write_q <= write_d;
        end
    end

    assign wr_lanes = ahb.HWSTRB & mask_q;

    // Storage is deliberately not reset; a write commits on the completing edge of its data phase.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_lanes[b]) begin
                    mem_q[idx_q][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign ahb.HREADY = hready;
    assign ahb.HRESP  = hresp;
    assign ahb.HRDATA = rd_en ? mem_q[idx_q] : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vx_ahb_subordinate_mem.sv
// Directed bench for vx_ahb_subordinate_mem: one instance with no wait states, one with two.
// Beats are queued, then driven as a pipelined AHB sequence with results checked per data phase.
module tb_vx_ahb_subordinate_mem;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_ahb_subordinate_mem_if bus0 ();
    vx_ahb_subordinate_mem_if bus2 ();
    logic [2:0] dbg0;
    logic [2:0] dbg2;

    vx_ahb_subordinate_mem #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .ahb(bus0.slave), .dbg_state(dbg0)
    );
    vx_ahb_subordinate_mem #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .ahb(bus2.slave), .dbg_state(dbg2)
    );

    // Shared manager drive; sel2 routes HSEL and observation to the two-wait-state instance.
    logic        sel2;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;

    assign bus0.HSEL   = hsel & ~sel2;
    assign bus2.HSEL   = hsel & sel2;
    assign bus0.HTRANS = htrans;
    assign bus2.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus2.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus2.HSIZE  = hsize;
    assign bus0.HADDR  = haddr;
    assign bus2.HADDR  = haddr;
    assign bus0.HWDATA = hwdata;
    assign bus2.HWDATA = hwdata;
    assign bus0.HWSTRB = hwstrb;
    assign bus2.HWSTRB = hwstrb;

    wire        hready = sel2 ? bus2.HREADY : bus0.HREADY;
    wire        hresp  = sel2 ? bus2.HRESP  : bus0.HRESP;
    wire [31:0] hrdata = sel2 ? bus2.HRDATA : bus0.HRDATA;
    wire [2:0]  dbg    = sel2 ? dbg2 : dbg0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        resp;
        int          waits;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected wait count comes from the selected instance: 0 or 2 for OKAY, always 1 for ERROR.
    task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic err);
        beat_t b;
        b.wr    = wr;
        b.addr  = addr;
        b.size  = size;
        b.data  = data;
        b.strb  = strb;
        b.resp  = err;
        b.waits = err ? 1 : (sel2 ? 2 : 0);
        beats.push_back(b);
        exp_q.push_back((wr || err) ? 32'h0 : exp_rd);
    endtask

    task automatic wr_w(input logic [31:0] addr, input logic [31:0] data);
        add(1'b1, addr, 3'b010, data, 4'hF, 32'h0, 1'b0);
    endtask

    task automatic rd_w(input logic [31:0] addr, input logic [31:0] exp_rd);
        add(1'b0, addr, 3'b010, 32'h0, 4'h0, exp_rd, 1'b0);
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = 32'h0;
    endtask

    task automatic run_seq(input string tag);
        int          n;
        int          waits;
        logic        resp_wait;
        logic [31:0] exp_rd;
        n = beats.size();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                hwdata = beats[i-1].data;
                hwstrb = beats[i-1].strb;
            end
            if (i < n) begin
                hsel   = 1'b1;
                htrans = 2'b10;
                hwrite = beats[i].wr;
                hsize  = beats[i].size;
                haddr  = beats[i].addr;
            end else begin
                drive_idle();
            end
            if (i == 0) begin
                check({tag, "_start_hready"}, 32'(hready), 32'd1);
            end else begin
                waits     = 0;
                resp_wait = 1'b0;
                while (!hready && waits < 16) begin
                    if (waits == 0) resp_wait = hresp;
                    @(negedge clk);
                    waits++;
                end
                exp_rd = exp_q.pop_front();
                check($sformatf("%s_b%0d_waits", tag, i-1), 32'(waits), 32'(beats[i-1].waits));
                if (waits > 0)
                    check($sformatf("%s_b%0d_wresp", tag, i-1), 32'(resp_wait), 32'(beats[i-1].resp));
                check($sformatf("%s_b%0d_resp", tag, i-1), 32'(hresp), 32'(beats[i-1].resp));
                check($sformatf("%s_b%0d_rdata", tag, i-1), hrdata, exp_rd);
            end
            @(posedge clk);
        end
        beats.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        sel2   = 1'b0;
        hwdata = 32'h0;
        hwstrb = 4'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hready0", 32'(bus0.HREADY), 32'd1);
        check("rst_hresp0",  32'(bus0.HRESP),  32'd0);
        check("rst_hrdata0", bus0.HRDATA,      32'd0);
        check("rst_state0",  32'(dbg0),        32'd0);
        check("rst_hready2", 32'(bus2.HREADY), 32'd1);
        check("rst_state2",  32'(dbg2),        32'd0);
        reset = 1'b0;

        // Write then read back-to-back with no wait states.
        wr_w(32'h40, 32'hDEADBEEF);
        rd_w(32'h40, 32'hDEADBEEF);
        run_seq("t1");

        // Byte/halfword lanes and strobes combined with the size/address lane mask.
        wr_w(32'h08, 32'h11223344);
        add(1'b1, 32'h0A, 3'b000, 32'h00AA0000, 4'b0100, 32'h0, 1'b0);
        add(1'b1, 32'h09, 3'b000, 32'h0000FF00, 4'b0001, 32'h0, 1'b0);
        wr_w(32'h0C, 32'h55667788);
        add(1'b1, 32'h0E, 3'b001, 32'hBEEF0000, 4'b1111, 32'h0, 1'b0);
        wr_w(32'h10, 32'hCAFEF00D);
        add(1'b1, 32'h10, 3'b010, 32'h12345678, 4'b0011, 32'h0, 1'b0);
        rd_w(32'h08, 32'h11AA3344);
        rd_w(32'h0C, 32'hBEEF7788);
        rd_w(32'h10, 32'hCAFE5678);
        run_seq("t3");

        // Out-of-range, misaligned and oversize transfers answer ERROR and leave storage alone.
        wr_w(32'h0, 32'h0BADF00D);
        wr_w(32'h3FFC, 32'h600DCAFE);
        add(1'b0, 32'h4000, 3'b010, 32'h0, 4'h0, 32'h0, 1'b1);
        add(1'b1, 32'h2, 3'b010, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        add(1'b1, 32'h0, 3'b011, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        add(1'b1, 32'h1, 3'b001, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        rd_w(32'h0, 32'h0BADF00D);
        rd_w(32'h3FFC, 32'h600DCAFE);
        run_seq("t4");

        // Sixteen-beat write burst then read burst, one beat per cycle.
        for (int i = 0; i < 16; i++) wr_w(32'h100 + 32'(i) * 4, 32'hC0DE0000 + 32'(i) * 32'h01010101);
        for (int i = 0; i < 16; i++) rd_w(32'h100 + 32'(i) * 4, 32'hC0DE0000 + 32'(i) * 32'h01010101);
        run_seq("t5");

        // Two wait states: pipelined next beats must stall until HREADY returns.
        sel2 = 1'b1;
        wr_w(32'h0, 32'h13579BDF);
        wr_w(32'h4, 32'h2468ACE0);
        rd_w(32'h0, 32'h13579BDF);
        rd_w(32'h4, 32'h2468ACE0);
        add(1'b0, 32'h4000, 3'b010, 32'h0, 4'h0, 32'h0, 1'b1);
        rd_w(32'h0, 32'h13579BDF);
        run_seq("t2");

        // Reset during the wait phase of a write abandons it.
        wr_w(32'h20, 32'h12345678);
        run_seq("t6_pre");
        @(negedge clk);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'b010;
        haddr  = 32'h20;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        hwdata = 32'hFFFFFFFF;
        hwstrb = 4'hF;
        check("t6_in_wait_hready", 32'(hready), 32'd0);
        check("t6_in_wait_state",  32'(dbg),    32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_hready", 32'(hready), 32'd1);
        check("t6_rst_hresp",  32'(hresp),  32'd0);
        check("t6_rst_hrdata", hrdata,      32'd0);
        check("t6_rst_state",  32'(dbg),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_w(32'h20, 32'h12345678);
        wr_w(32'h20, 32'hA0A0A0A0);
        rd_w(32'h20, 32'hA0A0A0A0);
        run_seq("t6_post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
